// File: rtl/trng_word_collector.sv
// TRNG consumer: RCT/APT health tests on accepted bits, LSB-first word packing, small output FIFO.
// Word visible one cycle after its last bit; a health trip drops the partial word and flushes the FIFO.
module trng_word_collector #(
  parameter int WORD_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int RCT_CUTOFF = 21,
  parameter int APT_WINDOW = 1024,
  parameter int APT_CUTOFF = 589
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          bit_in,
  input  logic                          bit_valid,
  input  logic                          clear_fail,
  output logic [WORD_W-1:0]             word_data,
  output logic                          word_valid,
  input  logic                          word_ready,
  output logic                          health_fail,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = $clog2(WORD_W);
  localparam int RUN_W = $clog2(RCT_CUTOFF + 1);
  localparam int IDX_W = $clog2(APT_WINDOW);
  localparam int MAT_W = $clog2(APT_WINDOW + 1);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);
  localparam logic [RUN_W-1:0] RUN_TRIP = RUN_W'(RCT_CUTOFF);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(APT_WINDOW - 1);
  localparam logic [MAT_W-1:0] MAT_TRIP = MAT_W'(APT_CUTOFF);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

  logic [WORD_W-1:0] sr_q, sr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic              prev_q, prev_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              ref_q, ref_d;
  logic [MAT_W-1:0]  mat_q, mat_d;
  logic              fail_q, fail_d;
  logic              ovf_q, ovf_d;
  logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
  logic [WORD_W-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [LVL_W-1:0]  lvl_q, lvl_d;

  logic              acc, trip, word_done, pop, push_ok;
  logic [RUN_W-1:0]  run_nx;
  logic [MAT_W-1:0]  mat_nx;
  logic [WORD_W-1:0] full_word;

  assign word_valid  = (lvl_q != '0);
  assign word_data   = word_valid ? mem_q[rd_q] : '0;
  assign health_fail = fail_q;
  assign overflow    = ovf_q;
  assign fifo_level  = lvl_q;

  always_comb begin
    acc       = enable & bit_valid & ~fail_q & ~clear_fail;
    run_nx    = ((run_q == '0) || (bit_in != prev_q)) ? RUN_W'(1) :
                (run_q == RUN_TRIP) ? run_q : run_q + RUN_W'(1);
    // At window start the bit becomes the reference and counts as its own match.
    mat_nx    = (idx_q == '0) ? MAT_W'(1) : mat_q + MAT_W'(bit_in == ref_q);
    trip      = acc & ((run_nx == RUN_TRIP) | (mat_nx == MAT_TRIP));
    word_done = acc & ~trip & (cnt_q == LAST_BIT);
    full_word = {bit_in, sr_q[WORD_W-1:1]};
    pop       = word_valid & word_ready & ~trip;
    push_ok   = word_done & ((lvl_q != LVL_FULL) | pop);

    sr_d   = sr_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    prev_d = prev_q;
    idx_d  = idx_q;
    ref_d  = ref_q;
    mat_d  = mat_q;
    fail_d = fail_q;
    ovf_d  = ovf_q;
    mem_d  = mem_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    lvl_d  = lvl_q;

    if (clear_fail) begin
      run_d  = '0;
      prev_d = 1'b0;
      idx_d  = '0;
      ref_d  = 1'b0;
      mat_d  = '0;
      cnt_d  = '0;
      fail_d = 1'b0;
    end else if (acc) begin
      run_d  = run_nx;
      prev_d = bit_in;
      mat_d  = mat_nx;
      if (idx_q == '0) ref_d = bit_in;
      idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
      if (trip) begin
        fail_d = 1'b1;
        cnt_d  = '0;
      end else begin
        sr_d  = full_word;
        cnt_d = word_done ? '0 : cnt_q + CNT_W'(1);
      end
    end

    if (trip) begin
      wr_d  = '0;
      rd_d  = '0;
      lvl_d = '0;
    end else begin
      if (pop) rd_d = rd_q + PTR_W'(1);
      if (push_ok) begin
        mem_d[wr_q] = full_word;
        wr_d        = wr_q + PTR_W'(1);
      end
      if (word_done & ~push_ok) ovf_d = 1'b1;
      lvl_d = lvl_q + LVL_W'(push_ok) - LVL_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr_q   <= '0;
      cnt_q  <= '0;
      run_q  <= '0;
      prev_q <= 1'b0;
      idx_q  <= '0;
      ref_q  <= 1'b0;
      mat_q  <= '0;
      fail_q <= 1'b0;
      ovf_q  <= 1'b0;
      wr_q   <= '0;
      rd_q   <= '0;
      lvl_q  <= '0;
    end else begin
      sr_q   <= sr_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      prev_q <= prev_d;
      idx_q  <= idx_d;
      ref_q  <= ref_d;
      mat_q  <= mat_d;
      fail_q <= fail_d;
      ovf_q  <= ovf_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      lvl_q  <= lvl_d;
    end
  end

  // Storage needs no reset: word_data is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_trng_word_collector.sv
// Randomized + directed bench for trng_word_collector with a queue-based reference model and scoreboard.
module tb_trng_word_collector;
  localparam int W    = 32;
  localparam int D    = 4;
  localparam int RCT  = 21;
  localparam int WIN  = 1024;
  localparam int APTC = 589;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n = 1'b0, enable = 1'b0, bit_in = 1'b0, bit_valid = 1'b0;
  logic         clear_fail = 1'b0, word_ready = 1'b0;
  logic [W-1:0] word_data;
  logic         word_valid, health_fail, overflow;
  logic [2:0]   fifo_level;

  trng_word_collector #(.WORD_W(W), .FIFO_DEPTH(D), .RCT_CUTOFF(RCT),
                        .APT_WINDOW(WIN), .APT_CUTOFF(APTC)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .bit_in(bit_in), .bit_valid(bit_valid),
    .clear_fail(clear_fail), .word_data(word_data), .word_valid(word_valid),
    .word_ready(word_ready), .health_fail(health_fail), .overflow(overflow),
    .fifo_level(fifo_level));

  int checks = 0;
  int errors = 0;

  // Model state: expected FIFO contents, sticky flags, and bit histories.
  logic [W-1:0] exp_q[$];
  bit fail_m = 0, ovf_m = 0, mon_on = 0;
  bit run_hist[$];   // current run of identical accepted bits
  bit win_hist[$];   // accepted bits of the current APT window
  bit cur[$];        // bits of the partial word
  bit p_rst = 0, p_clr = 0, p_fail = 0, p_push = 0, p_ovf = 0;
  logic [W-1:0] p_word = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      chk("health_fail", 32'(health_fail), 32'(fail_m));
      chk("overflow", 32'(overflow), 32'(ovf_m));
      chk("fifo_level", 32'(fifo_level), 32'(exp_q.size()));
      chk("word_valid", 32'(word_valid), 32'(exp_q.size() != 0));
      if (word_valid && word_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL word_pop: got unexpected word %h expected none", word_data);
        end else begin
          chk("word_data", word_data, exp_q[0]);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // One clock: commit effects predicted for the edge just passed, then drive and predict the next edge.
  task automatic cyc(input bit rst, input bit en, input bit bv, input bit b, input bit clr, input bit rdy);
    int mat;
    logic [W-1:0] wd;
    @(posedge clk);
    #1;
    if (p_rst) begin
      exp_q.delete();
      fail_m = 0;
      ovf_m  = 0;
      mon_on = 1;
    end else begin
      if (p_clr) fail_m = 0;
      if (p_fail) begin
        fail_m = 1;
        exp_q.delete();
      end
      if (p_push) exp_q.push_back(p_word);
      if (p_ovf) ovf_m = 1;
    end
    p_rst = 0; p_clr = 0; p_fail = 0; p_push = 0; p_ovf = 0;

    rst_n = rst; enable = en; bit_valid = bv; bit_in = b; clear_fail = clr; word_ready = rdy;

    if (!rst || clr) begin
      p_rst = !rst;
      p_clr = rst;
      run_hist.delete();
      win_hist.delete();
      cur.delete();
    end else if (en && bv && !fail_m) begin
      if (run_hist.size() > 0 && run_hist[$] != b) run_hist.delete();
      run_hist.push_back(b);
      if (win_hist.size() == WIN) win_hist.delete();
      win_hist.push_back(b);
      mat = 0;
      foreach (win_hist[i]) if (win_hist[i] == win_hist[0]) mat++;
      if (run_hist.size() == RCT || mat == APTC) begin
        p_fail = 1;
        cur.delete();
      end else begin
        cur.push_back(b);
        if (cur.size() == W) begin
          wd = '0;
          foreach (cur[i]) wd[i] = cur[i];
          cur.delete();
          if (exp_q.size() < D || (exp_q.size() > 0 && rdy)) begin
            p_push = 1;
            p_word = wd;
          end else begin
            p_ovf = 1;
          end
        end
      end
    end
  endtask

  task automatic send(input bit b, input bit rdy);
    cyc(1, 1, 1, b, 0, rdy);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cyc(1, 1, 0, 0, 0, rdy);
  endtask

  task automatic do_reset();
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    idle(1, 0);
  endtask

  initial begin
    logic [31:0] pat;
    int bias;

    // T1: reset values, then 31 bits never produce a word
    do_reset();
    @(negedge clk);
    chk("rst_word_data", word_data, 32'h0);
    chk("rst_word_valid", 32'(word_valid), 32'h0);
    chk("rst_health_fail", 32'(health_fail), 32'h0);
    chk("rst_overflow", 32'(overflow), 32'h0);
    chk("rst_fifo_level", 32'(fifo_level), 32'h0);
    for (int i = 0; i < 31; i++) send(1'($urandom_range(0, 1)), 1);
    idle(3, 1);

    // T2: alternating bits pack to AAAAAAAA, visible for one cycle
    do_reset();
    for (int i = 0; i < 32; i++) send(1'(i % 2), 1);
    idle(1, 1);
    @(negedge clk);
    chk("t2_valid_up", 32'(word_valid), 32'h1);
    chk("t2_data", word_data, 32'hAAAAAAAA);
    idle(1, 1);
    @(negedge clk);
    chk("t2_valid_down", 32'(word_valid), 32'h0);
    chk("t2_health", 32'(health_fail), 32'h0);

    // T3: run of 20 is fine, run of 21 trips and flushes the buffered word
    do_reset();
    for (int i = 0; i < 20; i++) send(1, 0);
    send(0, 0);
    for (int i = 0; i < 21; i++) send(1, 0);
    idle(1, 0);
    @(negedge clk);
    chk("t3_fail", 32'(health_fail), 32'h1);
    chk("t3_level", 32'(fifo_level), 32'h0);
    for (int i = 0; i < 40; i++) send(1'($urandom_range(0, 1)), 1);

    // T6: clear, then 0F0F0F0F packs correctly
    cyc(1, 1, 1, 1, 1, 1);
    pat = 32'h0F0F0F0F;
    for (int i = 0; i < 32; i++) send(pat[i], 1);
    idle(1, 1);
    @(negedge clk);
    chk("t6_fail_cleared", 32'(health_fail), 32'h0);
    chk("t6_data", word_data, 32'h0F0F0F0F);
    idle(2, 1);

    // T4: backpressure fills the FIFO and the fifth word is lost
    do_reset();
    for (int i = 0; i < 160; i++) send(1'(i % 2), 0);
    idle(1, 0);
    @(negedge clk);
    chk("t4_level", 32'(fifo_level), 32'h4);
    chk("t4_overflow", 32'(overflow), 32'h1);
    idle(6, 1);

    // T5: last bit lands with FIFO full and a pop on the same edge
    do_reset();
    for (int i = 0; i < 159; i++) send(1'(i % 2), 0);
    send(1, 1);
    idle(1, 0);
    @(negedge clk);
    chk("t5_level", 32'(fifo_level), 32'h4);
    chk("t5_overflow", 32'(overflow), 32'h0);
    idle(6, 1);

    // APT: a 1,1,0 pattern never trips RCT but biases the window past the cutoff
    do_reset();
    for (int i = 0; i < 1000; i++) send(1'(i % 3 != 2), 1);
    idle(1, 1);
    @(negedge clk);
    chk("apt_fail", 32'(health_fail), 32'h1);
    cyc(1, 1, 0, 0, 1, 1);

    // Random traffic with varying bias, stalls, clears and occasional reset
    bias = 50;
    for (int n = 0; n < 6000; n++) begin
      if (n % 256 == 0) bias = ($urandom_range(0, 1) == 1) ? 92 : 50;
      cyc(($urandom_range(0, 699) != 0),
          ($urandom_range(0, 9) != 0),
          ($urandom_range(0, 9) < 7),
          ($urandom_range(0, 99) < bias),
          ($urandom_range(0, 99) == 0),
          ($urandom_range(0, 9) < 6));
    end

    // Drain with a bounded budget
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) idle(1, 1);
    idle(2, 1);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d words left expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
